// File: rtl/winner_banner_ctrl_if.sv
// Handshake bundle between game logic (master) and the winner banner sequencer (slave).
interface winner_banner_ctrl_if;
    logic       frame_tick;
    logic       game_over;
    logic       winner_id;
    logic       restart;
    logic [9:0] posx;
    logic [9:0] posy;
    logic       visible;
    logic       busy;
    logic [1:0] phase;
    logic       restart_req;

    modport master (
        output frame_tick, game_over, winner_id, restart,
        input  posx, posy, visible, busy, phase, restart_req
    );

    modport slave (
        input  frame_tick, game_over, winner_id, restart,
        output posx, posy, visible, busy, phase, restart_req
    );
endinterface

// File: rtl/winner_banner_ctrl.sv
// End-of-game winner banner sequencer: slide-in, blink, hold, cleared on restart.
// Optional auto-restart from HOLD enabled by defining WINNER_AUTO_RESTART_EN.
module winner_banner_ctrl #(
    parameter int unsigned SPRITE_H      = 75,
    parameter int unsigned TARGET_Y      = (480 - SPRITE_H) / 2,
    parameter int unsigned SPEED         = 4,
    parameter int unsigned LEFT_X        = 107,
    parameter int unsigned RIGHT_X       = 427,
    parameter int unsigned BLINK_FRAMES  = 15,
    parameter int unsigned BLINK_TOGGLES = 6
`ifdef WINNER_AUTO_RESTART_EN
    ,
    parameter int unsigned HOLD_FRAMES   = 300
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    winner_banner_ctrl_if.slave  bus
);

    localparam int unsigned FrameW  = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned ToggleW = $clog2(BLINK_TOGGLES + 1);
    localparam logic [FrameW-1:0]  FrameLast  = FrameW'(BLINK_FRAMES - 1);
    localparam logic [ToggleW-1:0] ToggleLast = ToggleW'(BLINK_TOGGLES - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSlide = 2'd1,
        StBlink = 2'd2,
        StHold  = 2'd3
    } state_e;

    state_e             r_state, w_state_d;
    logic [9:0]         r_posx, w_posx_d;
    logic [9:0]         r_posy, w_posy_d;
    logic               r_visible, w_visible_d;
    logic               r_busy;
    logic [FrameW-1:0]  r_frame_cnt, w_frame_d;
    logic [ToggleW-1:0] r_toggle_cnt, w_toggle_d;
    logic [10:0]        w_sum;

`ifdef WINNER_AUTO_RESTART_EN
    localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_FRAMES - 1);
    logic [HoldW-1:0] r_hold_cnt, w_hold_d;
    logic             r_restart_req, w_restart_req_d;
`endif

    // 11-bit sum so the overshoot past TARGET_Y is visible before clamping
    assign w_sum = {1'b0, r_posy} + 11'(SPEED);

    always_comb begin
        w_state_d   = r_state;
        w_posx_d    = r_posx;
        w_posy_d    = r_posy;
        w_visible_d = r_visible;
        w_frame_d   = r_frame_cnt;
        w_toggle_d  = r_toggle_cnt;
`ifdef WINNER_AUTO_RESTART_EN
        w_hold_d        = r_hold_cnt;
        w_restart_req_d = 1'b0;
`endif
        if (bus.restart) begin
            w_state_d   = StIdle;
            w_visible_d = 1'b0;
            w_frame_d   = '0;
            w_toggle_d  = '0;
`ifdef WINNER_AUTO_RESTART_EN
            w_hold_d    = '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.game_over) begin
                        w_posx_d    = bus.winner_id ? 10'(RIGHT_X) : 10'(LEFT_X);
                        w_posy_d    = '0;
                        w_visible_d = 1'b1;
                        w_frame_d   = '0;
                        w_toggle_d  = '0;
                        w_state_d   = StSlide;
                    end
                end
                StSlide: begin
                    if (bus.frame_tick) begin
                        if (w_sum >= 11'(TARGET_Y)) begin
                            w_posy_d   = 10'(TARGET_Y);
                            w_frame_d  = '0;
                            w_toggle_d = '0;
                            w_state_d  = StBlink;
                        end else begin
                            w_posy_d = w_sum[9:0];
                        end
                    end
                end
                StBlink: begin
                    if (bus.frame_tick) begin
                        if (r_frame_cnt == FrameLast) begin
                            w_frame_d   = '0;
                            w_visible_d = ~r_visible;
                            w_toggle_d  = r_toggle_cnt + 1'b1;
                            if (r_toggle_cnt == ToggleLast) begin
                                w_toggle_d = '0;
                                w_state_d  = StHold;
`ifdef WINNER_AUTO_RESTART_EN
                                w_hold_d   = '0;
`endif
                            end
                        end else begin
                            w_frame_d = r_frame_cnt + 1'b1;
                        end
                    end
                end
                StHold: begin
                    w_visible_d = 1'b1;
`ifdef WINNER_AUTO_RESTART_EN
                    if (bus.frame_tick) begin
                        if (r_hold_cnt == HoldLast) begin
                            w_hold_d        = '0;
                            w_restart_req_d = 1'b1;
                            w_visible_d     = 1'b0;
                            w_state_d       = StIdle;
                        end else begin
                            w_hold_d = r_hold_cnt + 1'b1;
                        end
                    end
`endif
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_posx       <= '0;
            r_posy       <= '0;
            r_visible    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_cnt  <= '0;
            r_toggle_cnt <= '0;
`ifdef WINNER_AUTO_RESTART_EN
            r_hold_cnt    <= '0;
            r_restart_req <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_d;
            r_posx       <= w_posx_d;
            r_posy       <= w_posy_d;
            r_visible    <= w_visible_d;
            r_busy       <= (w_state_d != StIdle);
            r_frame_cnt  <= w_frame_d;
            r_toggle_cnt <= w_toggle_d;
`ifdef WINNER_AUTO_RESTART_EN
            r_hold_cnt    <= w_hold_d;
            r_restart_req <= w_restart_req_d;
`endif
        end
    end

    assign bus.posx    = r_posx;
    assign bus.posy    = r_posy;
    assign bus.visible = r_visible;
    assign bus.busy    = r_busy;
    assign bus.phase   = r_state;
`ifdef WINNER_AUTO_RESTART_EN
    assign bus.restart_req = r_restart_req;
`else
    assign bus.restart_req = 1'b0;
`endif

endmodule

// File: tb/tb_winner_banner_ctrl.sv
// Directed bench for winner_banner_ctrl: per-cycle compare against a phase/tick-count model
// plus literal spot checks. Honours WINNER_AUTO_RESTART_EN like the design.
module tb_winner_banner_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_req = 0;
    logic cmp_en = 1'b0;

    winner_banner_ctrl_if bus ();

    winner_banner_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: phase plus number of frame ticks seen in the current phase.
    int m_phase, m_posx, m_posy, m_vis, m_n, m_req;

    always @(posedge clk or posedge reset) begin : model
        int n, ph, px, py, v, rq;
        if (reset) begin
            m_phase <= 0; m_posx <= 0; m_posy <= 0; m_vis <= 0; m_n <= 0; m_req <= 0;
        end else begin
            n = m_n; ph = m_phase; px = m_posx; py = m_posy; v = m_vis; rq = 0;
            if (bus.restart) begin
                ph = 0; v = 0; n = 0;
            end else if (ph == 0) begin
                if (bus.game_over) begin
                    px = bus.winner_id ? 427 : 107; py = 0; v = 1; ph = 1; n = 0;
                end
            end else if (ph == 1) begin
                if (bus.frame_tick) begin
                    n++;
                    if (4 * n >= 202) begin py = 202; ph = 2; n = 0; end
                    else py = 4 * n;
                end
            end else if (ph == 2) begin
                if (bus.frame_tick) begin
                    n++;
                    v = ((n / 15) % 2 == 0) ? 1 : 0;
                    if (n == 90) begin ph = 3; n = 0; end
                end
            end else begin
                v = 1;
`ifdef WINNER_AUTO_RESTART_EN
                if (bus.frame_tick) begin
                    n++;
                    if (n == 300) begin rq = 1; ph = 0; v = 0; n = 0; end
                end
`endif
            end
            m_phase <= ph; m_posx <= px; m_posy <= py; m_vis <= v; m_n <= n; m_req <= rq;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (bus.restart_req === 1'b1) n_req++;
        if (cmp_en) begin
            check("phase", int'(bus.phase), m_phase);
            check("posx", int'(bus.posx), m_posx);
            check("posy", int'(bus.posy), m_posy);
            check("visible", int'(bus.visible), m_vis);
            check("busy", int'(bus.busy), (m_phase != 0) ? 1 : 0);
            check("restart_req", int'(bus.restart_req), m_req);
        end
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1; cycle();
        bus.frame_tick = 1'b0; cycle();
    endtask

    task automatic go(input logic w);
        bus.game_over = 1'b1; bus.winner_id = w; cycle();
        bus.game_over = 1'b0; bus.winner_id = 1'b0;
    endtask

    task automatic do_restart();
        bus.restart = 1'b1; cycle();
        bus.restart = 1'b0;
    endtask

    logic exp_vis [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        bus.frame_tick = 1'b0; bus.game_over = 1'b0; bus.winner_id = 1'b0; bus.restart = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_phase", int'(bus.phase), 0);
        check("rst_posx", int'(bus.posx), 0);
        check("rst_visible", int'(bus.visible), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_restart_req", int'(bus.restart_req), 0);
        reset = 1'b0;
        cmp_en = 1'b1;
        cycle();

        // game_over with a simultaneous frame_tick: the tick must not move posy
        bus.frame_tick = 1'b1; go(1'b1); bus.frame_tick = 1'b0;
        check("go_tick_phase", int'(bus.phase), 1);
        check("go_tick_posy", int'(bus.posy), 0);
        check("go_posx_right", int'(bus.posx), 427);
        for (int i = 0; i < 25; i++) tick();
        check("slide_posy_100", int'(bus.posy), 100);

        // Asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1;
        check("async_posy", int'(bus.posy), 0);
        check("async_visible", int'(bus.visible), 0);
        check("async_phase", int'(bus.phase), 0);
        check("async_busy", int'(bus.busy), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        cycle();

        go(1'b1);
        for (int t = 1; t <= 51; t++) begin
            tick();
            if (t == 50) begin
                check("tick50_posy", int'(bus.posy), 200);
                check("tick50_phase", int'(bus.phase), 1);
            end
        end
        check("tick51_posy", int'(bus.posy), 202);
        check("tick51_phase", int'(bus.phase), 2);

        for (int t = 1; t <= 90; t++) begin
            tick();
            if (t % 15 == 0) check("blink_visible", int'(bus.visible), int'(exp_vis[t / 15 - 1]));
            if (t == 89) check("blink_phase_89", int'(bus.phase), 2);
        end
        check("hold_phase", int'(bus.phase), 3);
        check("hold_visible", int'(bus.visible), 1);

        go(1'b0);
        check("hold_ignore_go_posx", int'(bus.posx), 427);
        check("hold_ignore_go_phase", int'(bus.phase), 3);

        do_restart();
        check("restart_phase", int'(bus.phase), 0);
        check("restart_visible", int'(bus.visible), 0);
        check("restart_posx_kept", int'(bus.posx), 427);
        check("restart_posy_kept", int'(bus.posy), 202);

        // restart wins over game_over in IDLE
        bus.restart = 1'b1; go(1'b0); bus.restart = 1'b0;
        check("rst_vs_go_phase", int'(bus.phase), 0);
        check("rst_vs_go_visible", int'(bus.visible), 0);
        cycle();

        go(1'b0);
        check("go_posx_left", int'(bus.posx), 107);
        for (int t = 0; t < 51 + 90; t++) tick();
        check("hold2_phase", int'(bus.phase), 3);

        n_req = 0;
`ifdef WINNER_AUTO_RESTART_EN
        for (int t = 1; t <= 300; t++) begin
            tick();
            if (t == 299) check("hold_299_phase", int'(bus.phase), 3);
        end
        check("auto_req_pulses", n_req, 1);
        check("auto_phase", int'(bus.phase), 0);
        check("auto_visible", int'(bus.visible), 0);
`else
        for (int t = 0; t < 1000; t++) tick();
        check("noauto_req_pulses", n_req, 0);
        check("noauto_phase", int'(bus.phase), 3);
        do_restart();
        check("noauto_restart_phase", int'(bus.phase), 0);
`endif
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/winner_banner_ctrl.md
Name: winner_banner_ctrl

Overview:
Sequences the 105x75 winner sprite at end of game. Latches which player won. Drives the sprite's posx/posy and a visibility gate through four phases: slide-in from the top edge, blink, hold, and cleared on restart. Sits between the game-logic FSM and the sprite/pixel mux, and advances once per video frame.

Parameters:
SPRITE_H, 75, sprite height in pixels
TARGET_Y, 202, final posy, (480-75)/2
SPEED, 4, posy increment per frame tick during slide
LEFT_X, 107, posx when winner_id=0
RIGHT_X, 427, posx when winner_id=1
BLINK_FRAMES, 15, frame ticks per visibility toggle
BLINK_TOGGLES, 6, number of toggles in blink phase; must be even
HOLD_FRAMES, 300, auto-restart delay (optional feature only)

Ports:
clk  in  1  system/pixel clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame, at vsync start
game_over  in  1  one-cycle pulse: match ended
winner_id  in  1  winning side, sampled with game_over
restart  in  1  one-cycle pulse: clear banner
posx  out  10  sprite X origin
posy  out  10  sprite Y origin
visible  out  1  high = sprite pixels pass to screen mux
busy  out  1  high in any state except IDLE
phase  out  2  0=IDLE 1=SLIDE 2=BLINK 3=HOLD
restart_req  out  1  auto-restart pulse (optional feature; tied 0 otherwise)

Behaviour:
- All outputs are registered. On reset (async, immediate): state=IDLE, posx=0, posy=0, visible=0, busy=0, phase=0, restart_req=0, and all counters cleared.
- IDLE: on game_over, load posx=LEFT_X if winner_id=0, else RIGHT_X. Set posy=0, visible=1, go to SLIDE. Outputs update 1 cycle after the pulse. A frame_tick in the same cycle is not counted.
- SLIDE: on each frame_tick, if posy+SPEED >= TARGET_Y then posy=TARGET_Y, clear the frame and toggle counters, go to BLINK. Otherwise posy += SPEED. Compute the sum at 11 bits; posy never exceeds TARGET_Y. With the default parameters, 51 ticks take the block from SLIDE to BLINK.
- BLINK: count frame_ticks. At the BLINK_FRAMES-th tick, invert visible, increment the toggle counter, and clear the frame counter. After the BLINK_TOGGLES-th toggle, go to HOLD. visible ends at 1 because the toggle count is even. posx and posy hold.
- HOLD: visible=1, and posx/posy hold until restart.
- restart in any state: next cycle state=IDLE and visible=0. posx/posy keep their last values. restart has priority over game_over and frame_tick in the same cycle.
- game_over outside IDLE is ignored, and winner_id is not re-sampled.
- frame_tick outside SLIDE/BLINK is ignored.
- busy = (state != IDLE). phase encodes the state directly.
- Pixel gating is done downstream: final_rgb = visible ? sprite_rgb : background.

Optional Feature:
Macro: WINNER_AUTO_RESTART_EN.
- Defined: HOLD counts frame_ticks. At the HOLD_FRAMES-th tick, restart_req pulses high for exactly 1 cycle and the block returns to IDLE the same cycle, as if restart had arrived. An external restart during HOLD still clears immediately, with no restart_req.
- Not defined: there is no hold counter, restart_req is constant 0, and HOLD lasts until an external restart.

Test Plan:
- Reset mid-SLIDE with posy=100 -> posy=0, visible=0, phase=0, busy=0 immediately (asynchronous, no clock edge needed).
- game_over with winner_id=1, then 51 frame_ticks -> posx=427. posy goes 0,4,...,200, then 202 at tick 51, then phase=2. Tick 50 gives posy=200 with phase still 1.
- BLINK with defaults -> visible toggles at ticks 15,30,...,90 (0,1,0,1,0,1). phase=3 after tick 90 with visible=1.
- game_over with winner_id=0 during HOLD -> ignored: posx stays 427, phase stays 3. Then restart -> phase=0 and visible=0 next cycle, posx=427 retained.
- restart and game_over in the same cycle in IDLE -> stays IDLE, visible=0. game_over and frame_tick together in IDLE -> phase=1 with posy=0, not 4.
- WINNER_AUTO_RESTART_EN defined, 300 ticks in HOLD -> exactly one restart_req pulse and phase=0. Not defined -> 1000 ticks leave phase=3 and restart_req=0.
